// File: rtl/counter_load_arbiter_pkg.sv
// Shared definitions for the counter load arbiter.
// Contents:
//   CNT_W   - default data width, shared with the counter instance
//   state_t - FSM state encoding (IDLE=0, LOAD=1, CHECK=2, HOLD=3)
//   clog2   - ceiling log2, used to size index and guard registers
//   idx_w   - clog2 clamped to at least 1 bit, so NREQ=1 still has a grant_id
package counter_load_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/counter_load_arbiter_rr_pick.sv
// Combinational round-robin priority selector.
// Ports:
//   req   (in)  request vector, one bit per requester
//   ptr   (in)  index that has highest priority this round
//   found (out) 1 when any req bit is set
//   idx   (out) first set bit searching from ptr upward, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // Walk the offsets from farthest to nearest so the candidate closest to
  // ptr is the one that sticks.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter sharing the counter load port (wdata/wr) among NREQ
// requesters. Each transaction: grant -> one-cycle wr pulse -> read-back
// compare -> ack/err pulse -> GUARD idle cycles.
// Ports:
//   clk        (in)  system clock, rising edge
//   reset      (in)  asynchronous active-low reset
//   req        (in)  per-requester load request (level)
//   req_data   (in)  load values, requester i at [i*W +: W]
//   ack        (out) one-cycle pulse to the served requester
//   ack_err    (out) read-back mismatch flag, valid with ack, held to next check
//   cnt_wdata  (out) counter load value
//   cnt_wr     (out) counter load strobe
//   data_cnt   (in)  counter output, read back after the load
//   busy       (out) 1 in any state other than IDLE
//   grant_id   (out) index of current/last granted requester
//   state      (out) FSM state, for observation
// Handshake: a requester raises req with req_data and holds both stable; it
// is done when it sees its ack bit high for one cycle. A req that drops
// before being granted is simply never picked; changes after the grant are
// ignored because the value is latched into val at grant time.
module counter_load_arbiter
  import counter_load_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = CNT_W,
  parameter int GUARD = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0] ack,
  output logic            ack_err,
  output logic [W-1:0]    cnt_wdata,
  output logic            cnt_wr,
  input  logic [W-1:0]    data_cnt,
  output logic            busy,
  output logic [IW-1:0]   grant_id,
  output state_t          state
);

  localparam int GW = idx_w(GUARD + 1);

  state_t          state_n;
  logic [W-1:0]    val, val_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   grant_n;
  logic [GW-1:0]   guard, guard_n;
  logic [NREQ-1:0] ack_n;
  logic            err_n;
  logic [W-1:0]    wdata_n;
  logic            wr_n;
  logic            busy_n;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [W-1:0]    pick_data;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_data = req_data[int'(pick_idx)*W +: W];

  // Outputs are computed one state ahead and registered, so cnt_wr is high
  // during LOAD and ack/ack_err appear the cycle after CHECK.
  always_comb begin
    state_n = state;
    val_n   = val;
    ptr_n   = ptr;
    grant_n = grant_id;
    guard_n = guard;
    ack_n   = '0;
    err_n   = ack_err;
    wdata_n = '0;
    wr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          val_n   = pick_data;
          grant_n = pick_idx;
          wr_n    = 1'b1;
          wdata_n = pick_data;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The counter captures the value on the edge that ends LOAD.
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        ack_n[grant_id] = 1'b1;
        err_n           = (data_cnt != val);
        ptr_n           = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        if (GUARD == 0) begin
          state_n = ST_IDLE;
        end else begin
          guard_n = GW'(GUARD);
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (guard <= GW'(1)) begin
          guard_n = '0;
          state_n = ST_IDLE;
        end else begin
          guard_n = guard - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      val       <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      guard     <= '0;
      ack       <= '0;
      ack_err   <= 1'b0;
      cnt_wdata <= '0;
      cnt_wr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      val       <= val_n;
      ptr       <= ptr_n;
      grant_id  <= grant_n;
      guard     <= guard_n;
      ack       <= ack_n;
      ack_err   <= err_n;
      cnt_wdata <= wdata_n;
      cnt_wr    <= wr_n;
      busy      <= busy_n;
    end
  end

endmodule
